// File: rtl/axistream_forwarder_keep.sv
// Streams one stored packet from a word-addressed packet memory out as an AXI4-Stream
// master, generating TKEEP/TLAST from the byte length and absorbing memory latency in a skid buffer.
module axistream_forwarder_keep #(
    parameter int DATA_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 8,
    parameter int LEN_WIDTH   = 12,
    parameter int PESSIMISTIC = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ready_for_forwarder,
    input  logic [LEN_WIDTH-1:0]      len_to_forwarder,
    output logic [ADDR_WIDTH-1:0]     forwarder_rd_addr,
    output logic                      forwarder_rd_en,
    input  logic [DATA_WIDTH-1:0]     forwarder_rd_data,
    output logic                      forwarder_done,
    output logic [DATA_WIDTH-1:0]     TDATA,
    output logic [DATA_WIDTH/8-1:0]   TKEEP,
    output logic                      TVALID,
    output logic                      TLAST,
    input  logic                      TREADY
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LAT    = 1 + PESSIMISTIC;
    localparam int DEPTH  = 2 + PESSIMISTIC;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int REM_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int BEAT_W = ADDR_WIDTH + 1;
    localparam int CW     = ((LEN_WIDTH > BEAT_W) ? LEN_WIDTH : BEAT_W) + 1;
    localparam logic [CW-1:0]    MAX_BEATS = CW'(1) << ADDR_WIDTH;
    localparam logic [BYTES-1:0] KEEP_ONES = '1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, FINISH} state_t;

    state_t                  state;
    logic [BEAT_W-1:0]       beats;
    logic [REM_W-1:0]        rem;
    logic [BEAT_W-1:0]       issued;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    done_pulse;

    logic [LAT-1:0]          pipe_v;
    logic [LAT-1:0]          pipe_last;

    logic [DATA_WIDTH-1:0]   fifo_data [DEPTH];
    logic                    fifo_last [DEPTH];
    logic [PTR_W-1:0]        wptr;
    logic [PTR_W-1:0]        rptr;
    logic [CNT_W-1:0]        count;

    logic [CW-1:0]           len_ext;
    logic [CW-1:0]           full_words;
    logic [CW-1:0]           tail_bytes;
    logic [CW-1:0]           beats_raw;
    logic [BEAT_W-1:0]       beats_calc;
    logic [REM_W-1:0]        rem_calc;

    logic [CNT_W-1:0]        inflight;
    logic [CNT_W:0]          occ;
    logic                    pop;
    logic                    push;
    logic                    issue_last;
    logic                    head_last;
    logic [BYTES-1:0]        last_keep;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Oversized lengths are clamped to a full address space of whole words.
    always_comb begin
        len_ext    = CW'(len_to_forwarder);
        full_words = len_ext / CW'(BYTES);
        tail_bytes = len_ext % CW'(BYTES);
        beats_raw  = full_words + ((tail_bytes != '0) ? CW'(1) : CW'(0));
        beats_calc = beats_raw[BEAT_W-1:0];
        rem_calc   = tail_bytes[REM_W-1:0];
        if (beats_raw > MAX_BEATS) begin
            beats_calc = BEAT_W'(MAX_BEATS);
            rem_calc   = '0;
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_v[i]);
        end
    end

    assign TVALID     = (count != '0);
    assign pop        = TVALID & TREADY;
    assign push       = pipe_v[LAT-1];
    assign issue_last = (issued == beats - 1'b1);

    // A beat leaving this cycle frees its slot, which keeps one beat per cycle at the minimum depth.
    assign occ = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    assign forwarder_rd_en = (state == STREAM) && (issued < beats)
                             && (occ < (CNT_W + 1)'(DEPTH));

    assign forwarder_rd_addr = addr;
    assign forwarder_done    = done_pulse;

    assign head_last = fifo_last[rptr];
    assign last_keep = (rem == '0) ? KEEP_ONES : ~(KEEP_ONES >> rem);
    assign TDATA     = TVALID ? fifo_data[rptr] : '0;
    assign TLAST     = TVALID & head_last;
    assign TKEEP     = !TVALID ? '0 : (head_last ? last_keep : KEEP_ONES);

    // Reset clears the tracking pipe so late read data from an aborted packet is never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v    <= '0;
            pipe_last <= '0;
        end else begin
            pipe_v[0]    <= forwarder_rd_en;
            pipe_last[0] <= forwarder_rd_en & issue_last;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wptr] <= forwarder_rd_data;
            fifo_last[wptr] <= pipe_last[LAT-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beats      <= '0;
            rem        <= '0;
            issued     <= '0;
            addr       <= '0;
            done_pulse <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_pulse <= 1'b0;
                    issued     <= '0;
                    addr       <= '0;
                    if (ready_for_forwarder) begin
                        beats <= beats_calc;
                        rem   <= rem_calc;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (beats == '0) begin
                        state      <= FINISH;
                        done_pulse <= 1'b1;
                    end else begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (forwarder_rd_en) begin
                        issued <= issued + 1'b1;
                        if (addr != '1) addr <= addr + 1'b1;
                    end
                    if (pop && TLAST) begin
                        state      <= FINISH;
                        done_pulse <= 1'b1;
                    end
                end
                FINISH: begin
                    done_pulse <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axistream_forwarder_keep.sv
// Drives the forwarder with 1-cycle and 2-cycle packet memories side by side and
// checks every presented beat against a queue of expected beats per instance.
module tb_axistream_forwarder_keep;
    localparam int DW = 128;
    localparam int AW = 8;
    localparam int LW = 12;
    localparam int NB = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          ready;
    logic [LW-1:0] len;
    logic          tready;

    logic [AW-1:0] rd_addr [2];
    logic          rd_en   [2];
    logic [DW-1:0] rd_data [2];
    logic          done    [2];
    logic [DW-1:0] tdata   [2];
    logic [NB-1:0] tkeep   [2];
    logic          tvalid  [2];
    logic          tlast   [2];

    int    n_assert = 0;
    int    n_fail   = 0;
    int    cycle    = 0;
    int    done_cnt [2];
    int    acc_cnt  [2];
    int    first_cyc[2];
    int    last_cyc [2];
    int    first_addr[2];
    bit    addr_seen[2];
    bit    stall_prev[2];
    bit    pattern_mode;
    int    pat_idx;
    logic [5:0] pat_bits;
    beat_t exp_q [2][$];

    function automatic logic [DW-1:0] word(input int a);
        logic [DW-1:0] w;
        for (int k = 0; k < NB; k++) w[DW-1-8*k -: 8] = 8'(a * NB + k);
        return w;
    endfunction

    // Index 0 models a 1-cycle packet memory, index 1 a 2-cycle one.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            logic [DW-1:0] stage [gi+1];

            axistream_forwarder_keep #(
                .DATA_WIDTH (DW),
                .ADDR_WIDTH (AW),
                .LEN_WIDTH  (LW),
                .PESSIMISTIC(gi)
            ) dut (
                .clk                (clk),
                .rst_n              (rst_n),
                .ready_for_forwarder(ready),
                .len_to_forwarder   (len),
                .forwarder_rd_addr  (rd_addr[gi]),
                .forwarder_rd_en    (rd_en[gi]),
                .forwarder_rd_data  (rd_data[gi]),
                .forwarder_done     (done[gi]),
                .TDATA              (tdata[gi]),
                .TKEEP              (tkeep[gi]),
                .TVALID             (tvalid[gi]),
                .TLAST              (tlast[gi]),
                .TREADY             (tready)
            );

            always @(posedge clk) begin
                stage[0] <= rd_en[gi] ? word(int'(rd_addr[gi])) : {NB{8'hEE}};
                for (int k = 1; k <= gi; k++) stage[k] <= stage[k-1];
            end
            assign rd_data[gi] = stage[gi];
        end
    endgenerate

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive TREADY for the coming edge, then score what each instance presents.
    task automatic tick();
        beat_t cur;
        @(negedge clk);
        cycle++;
        if (pattern_mode) begin
            tready = pat_bits[pat_idx % 6];
            pat_idx++;
        end else begin
            tready = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            if (rst_n) begin
                cur = {tdata[i], tkeep[i], tlast[i]};
                if (stall_prev[i]) check($sformatf("tvalid_held_%0d", i), 160'(tvalid[i]), 160'(1));
                if (tvalid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("unexpected_beat_%0d", i), 160'(tvalid[i]), 160'(0));
                    end else begin
                        check($sformatf("beat_%0d_n%0d", i, acc_cnt[i]), 160'(cur), 160'(exp_q[i][0]));
                        if (tready) begin
                            void'(exp_q[i].pop_front());
                            acc_cnt[i]++;
                            if (first_cyc[i] < 0) first_cyc[i] = cycle;
                            last_cyc[i] = cycle;
                        end
                    end
                end
                stall_prev[i] = tvalid[i] && !tready;
                if (rd_en[i] && !addr_seen[i]) begin
                    addr_seen[i]  = 1'b1;
                    first_addr[i] = int'(rd_addr[i]);
                end
                if (done[i]) done_cnt[i]++;
            end
        end
    endtask

    function automatic int push_packet(input int plen);
        int nb;
        int r;
        logic [NB-1:0] all_keep;
        logic [NB-1:0] lk;
        beat_t b;
        all_keep = '1;
        nb = (plen + NB - 1) / NB;
        r  = plen % NB;
        if (nb > (1 << AW)) begin
            nb = 1 << AW;
            r  = 0;
        end
        lk = (r == 0) ? all_keep : NB'(all_keep << (NB - r));
        for (int k = 0; k < nb; k++) begin
            b.data = word(k);
            b.keep = (k == nb - 1) ? lk : all_keep;
            b.last = (k == nb - 1);
            for (int i = 0; i < 2; i++) exp_q[i].push_back(b);
        end
        return nb;
    endfunction

    task automatic start_tracking();
        for (int i = 0; i < 2; i++) begin
            first_cyc[i] = -1;
            last_cyc[i]  = -1;
            acc_cnt[i]   = 0;
            addr_seen[i] = 1'b0;
        end
    endtask

    task automatic send(input int plen, input bit check_span);
        int nb;
        int base[2];
        nb = push_packet(plen);
        start_tracking();
        for (int i = 0; i < 2; i++) base[i] = done_cnt[i];
        ready = 1'b1;
        len   = LW'(plen);
        tick();
        ready = 1'b0;
        for (int k = 0; k < 3000 && !(done_cnt[0] > base[0] && done_cnt[1] > base[1]); k++) tick();
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("len%0d_done_%0d", plen, i), 160'(done_cnt[i] - base[i]), 160'(1));
            check($sformatf("len%0d_drained_%0d", plen, i), 160'(exp_q[i].size()), 160'(0));
            check($sformatf("len%0d_first_addr_%0d", plen, i), 160'(first_addr[i]), 160'(0));
            if (check_span)
                check($sformatf("len%0d_span_%0d", plen, i), 160'(last_cyc[i] - first_cyc[i]), 160'(nb - 1));
        end
    endtask

    initial begin
        int base[2];
        int nb;
        bit seen0;
        bit seen1;

        rst_n        = 1'b0;
        ready        = 1'b0;
        len          = '0;
        tready       = 1'b1;
        pattern_mode = 1'b0;
        pat_idx      = 0;
        pat_bits     = 6'b101001;
        for (int i = 0; i < 2; i++) begin
            done_cnt[i]   = 0;
            stall_prev[i] = 1'b0;
            first_addr[i] = -1;
        end
        start_tracking();

        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_stream_%0d", i), 160'({tvalid[i], tlast[i], tkeep[i], tdata[i]}), 160'(0));
            check($sformatf("rst_mem_%0d", i), 160'({rd_en[i], rd_addr[i], done[i]}), 160'(0));
        end
        rst_n = 1'b1;
        repeat (2) tick();

        send(64, 1'b1);
        send(70, 1'b1);

        // Zero length: done two cycles after the request, no beat at all.
        for (int i = 0; i < 2; i++) base[i] = done_cnt[i];
        ready = 1'b1;
        len   = '0;
        tick();
        ready = 1'b0;
        for (int i = 0; i < 2; i++) check($sformatf("len0_done_c1_%0d", i), 160'(done[i]), 160'(0));
        tick();
        for (int i = 0; i < 2; i++) check($sformatf("len0_done_c2_%0d", i), 160'(done[i]), 160'(1));
        tick();
        for (int i = 0; i < 2; i++) check($sformatf("len0_done_c3_%0d", i), 160'(done[i]), 160'(0));
        repeat (3) tick();
        for (int i = 0; i < 2; i++) check($sformatf("len0_done_count_%0d", i), 160'(done_cnt[i] - base[i]), 160'(1));

        pattern_mode = 1'b1;
        send(48, 1'b0);
        pattern_mode = 1'b0;

        send(4095, 1'b1);

        // Abort a len=64 packet while beat 2 is presented; a short pulse leaves reads in flight.
        nb = push_packet(64);
        start_tracking();
        for (int i = 0; i < 2; i++) base[i] = done_cnt[i];
        ready = 1'b1;
        len   = LW'(64);
        tick();
        ready = 1'b0;
        for (int k = 0; k < 200 && acc_cnt[0] < 2; k++) tick();
        tick();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("abort_stream_%0d", i), 160'({tvalid[i], tlast[i], tkeep[i], tdata[i]}), 160'(0));
            check($sformatf("abort_mem_%0d", i), 160'({rd_en[i], rd_addr[i], done[i]}), 160'(0));
            exp_q[i].delete();
            stall_prev[i] = 1'b0;
        end
        #1;
        rst_n = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < 2; i++) check($sformatf("abort_no_done_%0d", i), 160'(done_cnt[i] - base[i]), 160'(0));
        send(16, 1'b1);

        // Back-to-back: request held high, second length offered once the first packet is done.
        nb = push_packet(17);
        nb = push_packet(16);
        start_tracking();
        for (int i = 0; i < 2; i++) base[i] = done_cnt[i];
        seen0 = 1'b0;
        seen1 = 1'b0;
        ready = 1'b1;
        len   = LW'(17);
        for (int k = 0; k < 400 && !(seen0 && seen1); k++) begin
            tick();
            if (done[0] && !seen0) begin
                seen0 = 1'b1;
                len   = LW'(16);
            end
            if (done[1]) seen1 = 1'b1;
        end
        repeat (2) tick();
        ready = 1'b0;
        for (int k = 0; k < 400 && !(done_cnt[0] >= base[0] + 2 && done_cnt[1] >= base[1] + 2); k++) tick();
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("b2b_done_count_%0d", i), 160'(done_cnt[i] - base[i]), 160'(2));
            check($sformatf("b2b_drained_%0d", i), 160'(exp_q[i].size()), 160'(0));
            check($sformatf("b2b_beats_%0d", i), 160'(acc_cnt[i]), 160'(3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
